mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store unit for the MIPS datapath. It sits directly upstream of the 1024×32 data memory, whose port is `addr[9:0]`, `din[31:0]`, `rw` (1 = write) and registered read output `S_datamemory`, updated on the read edge. The unit accepts one byte-addressed load or store at a time over a valid/ready handshake. It performs read-modify-write for byte and halfword stores, extracts and extends byte, halfword and word loads, and flags misaligned accesses without touching memory.

## Interface
- `ADDR_W`, 10: word-address width driven to memory.
- `clk`  in  1  rising-edge clock, shared with data memory.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; equals (state==IDLE) & !rst.
- `req_op`  in  3  operation: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; sh uses [15:0], sb uses [7:0].
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  1  misaligned access, qualified by rsp_valid.
- `mem_addr`  out  ADDR_W  word index to memory, = latched req_addr[ADDR_W+1:2].
- `mem_din`  out  32  write data to memory.
- `mem_rw`  out  1  1 = write; high only in WR state and gated by !rst.
- `mem_dout`  in  32  memory read data (`S_datamemory`).

## Operation
- Request handshake: a request is accepted at a rising edge where req_valid & req_ready are both high. On acceptance, op, addr and wdata are latched. Request inputs are ignored outside IDLE.
- Byte-lane convention: little-endian. Byte k occupies bits [8k+7:8k], where k = addr[1:0]. Halfword h = addr[1] occupies bits [16h+15:16h].
- Address range: bits above [ADDR_W+1] are ignored, so addresses wrap modulo 4 KiB.
- Misalignment: lw/sw with addr[1:0]≠0, or lh/lhu/sh with addr[0]=1, is misaligned. The unit goes IDLE→RESP with rsp_err=1 and makes no memory access.
- State machine: IDLE, RD, CAP, WR, RESP.
  - IDLE→RD for loads, sh and sb; IDLE→WR for sw; IDLE→RESP on a misaligned request.
  - RD: drives mem_addr with mem_rw=0. Memory captures the read at the edge ending RD. RD→CAP.
  - CAP: mem_dout is valid. For loads, the extracted data is registered into rsp_rdata and the unit goes CAP→RESP. lh/lb sign-extend; lhu/lbu zero-extend; lw passes the word. For sh/sb, the selected lane of mem_dout is replaced with wdata[15:0] or wdata[7:0], and the merged word is registered into mem_din; CAP→WR.
  - WR: mem_rw=1. For sw, mem_din = wdata. Memory writes at the edge ending WR. WR→RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then RESP→IDLE. rsp_rdata and rsp_err hold until the next RESP.
- Reset: rst high at an edge forces IDLE and clears rsp_valid, rsp_rdata, rsp_err and mem_din to 0. mem_addr resets to 0.
  - mem_rw is combinationally 0 while rst is high, so a reset asserted during WR suppresses the write.
  - An operation interrupted by reset produces no response.

## Timing
- Request accepted at edge ending cycle T. rsp_valid is high in:
  - cycle T+1 for a misaligned request;
  - cycle T+2 for sw;
  - cycle T+3 for lw/lh/lhu/lb/lbu;
  - cycle T+4 for sh/sb.
- req_ready is low from T+1 through the RESP cycle, and high again in the cycle after RESP. Maximum throughput is one sw per 3 cycles.
- mem_rw is high for exactly one cycle per store: T+1 for sw, T+3 for sh/sb.
- All outputs are registered or decoded from registered state only. There is no combinational path from req_* to mem_* or rsp_*.

## Test plan
- **Word load:** memory preloaded with M[1]=0x00000FA1; lw addr 0x4 → rsp_valid at T+3, rsp_rdata=0x00000FA1, rsp_err=0, mem_rw never high.
- **Sign/zero extension:** with M[2]=0x00001389:
  - lb 0x8 → 0xFFFFFF89;
  - lbu 0x8 → 0x00000089;
  - lh 0x8 → 0x00001389;
  - lb 0x9 → 0x00000013.
- **Byte store read-modify-write:** M[3]=0x00000BB9; sb addr 0xD, wdata 0x123456AB → mem_rw high in T+3 only with mem_din=0x0000ABB9 and mem_addr=3. A following lw 0xC returns 0x0000ABB9.
- **Word and halfword stores:**
  - sw addr 0x10, wdata 0xDEADBEEF → rsp_valid at T+2; then lh 0x12 → 0xFFFFDEAD.
  - sh addr 0x10, wdata 0x7777 on the same word → lw 0x10 → 0xDEAD7777.
- **Misalignment:** lw 0x6 and sh 0x11 → each gives rsp_valid at T+1 with rsp_err=1 and rsp_rdata=0. mem_rw stays 0 and the memory contents are unchanged.
- **Reset mid-operation:**
  - rst asserted during the WR cycle of sb to addr 0x0 → M[0] is unchanged (0x000007D1), no rsp_valid, req_ready=1 the cycle after rst deasserts.
  - A back-to-back request held on req_valid is accepted only once the unit is in IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit in front of the 1024x32 data memory: handshaked byte-addressed
// loads and stores, read-modify-write for sub-word stores, misalignment detection.
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_rw,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_t;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } op_t;

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    logic [1:0]          lane_q, lane_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_din_q, mem_din_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    op_t                 req_op_t;
    logic                unused_req_addr;

    // Addresses wrap modulo the memory size, so the upper byte-address bits are dropped.
    assign unused_req_addr = ^req_addr[31:ADDR_W+2];
    assign req_op_t        = op_t'(req_op);

    function automatic logic is_misaligned(input op_t op, input logic [1:0] lane);
        logic mis;
        case (op)
            OP_LW, OP_SW:         mis = (lane != 2'b00);
            OP_LH, OP_LHU, OP_SH: mis = lane[0];
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_load(input op_t op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic [31:0] extract_load(input op_t op, input logic [1:0] lane,
                                                  input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h000000, b};
            default: r = word;
        endcase
        return r;
    endfunction

    // Only the addressed lane is replaced; the rest of the word comes from the read.
    function automatic logic [31:0] merge_store(input op_t op, input logic [1:0] lane,
                                                 input logic [31:0] word,
                                                 input logic [31:0] wdata);
        logic [31:0] r;
        r = word;
        if (op == OP_SH) begin
            r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        end else begin
            r[{lane, 3'b000} +: 8] = wdata[7:0];
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d       = req_op_t;
                    lane_d     = req_addr[1:0];
                    wdata_d    = req_wdata;
                    mem_addr_d = req_addr[ADDR_W+1:2];
                    if (is_misaligned(req_op_t, req_addr[1:0])) begin
                        rsp_rdata_d = 32'h0;
                        rsp_err_d   = 1'b1;
                        state_d     = RESP;
                    end else if (req_op_t == OP_SW) begin
                        mem_din_d = req_wdata;
                        state_d   = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                if (is_load(op_q)) begin
                    rsp_rdata_d = extract_load(op_q, lane_q, mem_dout);
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    mem_din_d = merge_store(op_q, lane_q, mem_dout, wdata_q);
                    state_d   = WR;
                end
            end
            WR: begin
                rsp_rdata_d = 32'h0;
                rsp_err_d   = 1'b0;
                state_d     = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_LW;
            lane_q      <= 2'b00;
            wdata_q     <= 32'h0;
            mem_addr_q  <= '0;
            mem_din_q   <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Gating with rst lets a reset landing in WR suppress the pending write.
    assign req_ready = (state_q == IDLE) && !rst;
    assign mem_rw    = (state_q == WR) && !rst;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 1024x32 data memory
// whose read output is registered on the clock edge.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_rw;
    logic [31:0] mem_dout;

    logic [31:0] mem_model [0:1023];

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                           LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

    mem_access_unit #(.ADDR_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_rw    (mem_rw),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rw) mem_model[mem_addr] <= mem_din;
        mem_dout <= mem_model[mem_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE and watches up to 8 cycles for its response.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 output int lat, output logic [31:0] rdata,
                                 output logic err, output int rw_count,
                                 output int rw_cycle, output logic [31:0] rw_din,
                                 output logic [31:0] rw_addr, output int ready_bad,
                                 output logic ready_after);
        lat = 0; rdata = 32'hx; err = 1'bx; rw_count = 0; rw_cycle = 0;
        rw_din = 32'h0; rw_addr = 32'h0; ready_bad = 0; ready_after = 1'b0;
        req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        nextCycle();
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_rw) begin
                rw_count++;
                rw_cycle = c;
                rw_din   = mem_din;
                rw_addr  = {22'h0, mem_addr};
            end
            if (req_ready) ready_bad++;
            if (rsp_valid) begin
                lat   = c;
                rdata = rsp_rdata;
                err   = rsp_err;
                break;
            end
            nextCycle();
        end
        if (lat != 0) begin
            nextCycle();
            ready_after = req_ready && !rsp_valid;
        end
    endtask

    int          lat, rw_count, rw_cycle, ready_bad;
    logic [31:0] rdata, rw_din, rw_addr;
    logic        err, ready_after;

    task automatic loadCheck(input string tag, input logic [2:0] op,
                             input logic [31:0] addr, input logic [31:0] exp_data);
        applyStimulus(op, addr, 32'h0, lat, rdata, err, rw_count, rw_cycle, rw_din,
                      rw_addr, ready_bad, ready_after);
        checkOutput({tag, " latency"}, 32'(lat), 32'd3);
        checkOutput({tag, " rdata"}, rdata, exp_data);
        checkOutput({tag, " err"}, {31'h0, err}, 32'h0);
        checkOutput({tag, " writes"}, 32'(rw_count), 32'd0);
        checkOutput({tag, " ready low while busy"}, 32'(ready_bad), 32'd0);
        checkOutput({tag, " ready after resp"}, {31'h0, ready_after}, 32'h1);
    endtask

    task automatic storeCheck(input string tag, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int exp_lat, input int exp_rw_cycle,
                              input logic [31:0] exp_din);
        applyStimulus(op, addr, wdata, lat, rdata, err, rw_count, rw_cycle, rw_din,
                      rw_addr, ready_bad, ready_after);
        checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, " rdata"}, rdata, 32'h0);
        checkOutput({tag, " err"}, {31'h0, err}, 32'h0);
        checkOutput({tag, " writes"}, 32'(rw_count), 32'd1);
        checkOutput({tag, " write cycle"}, 32'(rw_cycle), 32'(exp_rw_cycle));
        checkOutput({tag, " mem_din"}, rw_din, exp_din);
        checkOutput({tag, " mem_addr"}, rw_addr, {22'h0, addr[11:2]});
        checkOutput({tag, " ready after resp"}, {31'h0, ready_after}, 32'h1);
    endtask

    task automatic misalignCheck(input string tag, input logic [2:0] op,
                                 input logic [31:0] addr);
        applyStimulus(op, addr, 32'hFFFF_FFFF, lat, rdata, err, rw_count, rw_cycle,
                      rw_din, rw_addr, ready_bad, ready_after);
        checkOutput({tag, " latency"}, 32'(lat), 32'd1);
        checkOutput({tag, " rdata"}, rdata, 32'h0);
        checkOutput({tag, " err"}, {31'h0, err}, 32'h1);
        checkOutput({tag, " writes"}, 32'(rw_count), 32'd0);
    endtask

    initial begin
        int          rsp_count;
        int          rsp_cyc [2];
        logic [31:0] rsp_dat [2];
        logic        rw_seen;

        for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
        mem_model[0] = 32'h0000_07D1;
        mem_model[1] = 32'h0000_0FA1;
        mem_model[2] = 32'h0000_1389;
        mem_model[3] = 32'h0000_0BB9;

        rst = 1'b1; req_valid = 1'b0; req_op = LW; req_addr = 32'h0; req_wdata = 32'h0;
        nextCycle();
        nextCycle();
        checkOutput("ready during reset", {31'h0, req_ready}, 32'h0);
        checkOutput("mem_rw during reset", {31'h0, mem_rw}, 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("reset ready", {31'h0, req_ready}, 32'h1);
        checkOutput("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset rsp_err", {31'h0, rsp_err}, 32'h0);
        checkOutput("reset mem_din", mem_din, 32'h0);
        checkOutput("reset mem_addr", {22'h0, mem_addr}, 32'h0);
        nextCycle();

        $display("[TB] loads and extension");
        loadCheck("lw 0x4", LW, 32'h4, 32'h0000_0FA1);
        loadCheck("lb 0x8", LB, 32'h8, 32'hFFFF_FF89);
        loadCheck("lbu 0x8", LBU, 32'h8, 32'h0000_0089);
        loadCheck("lh 0x8", LH, 32'h8, 32'h0000_1389);
        loadCheck("lb 0x9", LB, 32'h9, 32'h0000_0013);

        $display("[TB] stores");
        storeCheck("sb 0xD", SB, 32'hD, 32'h1234_56AB, 4, 3, 32'h0000_ABB9);
        loadCheck("lw 0xC", LW, 32'hC, 32'h0000_ABB9);
        storeCheck("sw 0x10", SW, 32'h10, 32'hDEAD_BEEF, 2, 1, 32'hDEAD_BEEF);
        loadCheck("lh 0x12", LH, 32'h12, 32'hFFFF_DEAD);
        storeCheck("sh 0x10", SH, 32'h10, 32'h0000_7777, 4, 3, 32'hDEAD_7777);
        loadCheck("lw 0x10", LW, 32'h10, 32'hDEAD_7777);
        loadCheck("lhu 0x12", LHU, 32'h12, 32'h0000_DEAD);
        loadCheck("lb 0x13", LB, 32'h13, 32'hFFFF_FFDE);
        loadCheck("lw wrap 0x1004", LW, 32'h0000_1004, 32'h0000_0FA1);

        $display("[TB] misalignment");
        misalignCheck("lw 0x6", LW, 32'h6);
        misalignCheck("sh 0x11", SH, 32'h11);
        loadCheck("lw 0x4 after misaligned", LW, 32'h4, 32'h0000_0FA1);
        loadCheck("lw 0x10 after misaligned", LW, 32'h10, 32'hDEAD_7777);

        $display("[TB] reset during sb write");
        req_op = SB; req_addr = 32'h0; req_wdata = 32'h0000_00EE; req_valid = 1'b1;
        nextCycle();
        req_valid = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("sb reaches WR", {31'h0, mem_rw}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("mem_rw gated by rst", {31'h0, mem_rw}, 32'h0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("M[0] after aborted sb", mem_model[0], 32'h0000_07D1);
        rw_seen = 1'b0;
        rsp_count = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid) rsp_count++;
            if (mem_rw) rw_seen = 1'b1;
            if (c == 1) checkOutput("ready after rst release", {31'h0, req_ready}, 32'h1);
            nextCycle();
        end
        checkOutput("no rsp after reset", 32'(rsp_count), 32'd0);
        checkOutput("no write after reset", {31'h0, rw_seen}, 32'h0);
        loadCheck("lw 0x0 after abort", LW, 32'h0, 32'h0000_07D1);

        $display("[TB] back-to-back held request");
        req_op = LW; req_addr = 32'h4; req_wdata = 32'h0; req_valid = 1'b1;
        nextCycle();
        rsp_count = 0;
        rsp_cyc[0] = 0; rsp_cyc[1] = 0; rsp_dat[0] = 32'h0; rsp_dat[1] = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 1) begin
                req_op = LBU; req_addr = 32'h8;
                checkOutput("held req ready low", {31'h0, req_ready}, 32'h0);
            end
            if (c == 5) req_valid = 1'b0;
            if (rsp_valid) begin
                if (rsp_count < 2) begin
                    rsp_cyc[rsp_count] = c;
                    rsp_dat[rsp_count] = rsp_rdata;
                end
                rsp_count++;
            end
            nextCycle();
        end
        checkOutput("b2b rsp count", 32'(rsp_count), 32'd2);
        checkOutput("b2b first cycle", 32'(rsp_cyc[0]), 32'd3);
        checkOutput("b2b first data", rsp_dat[0], 32'h0000_0FA1);
        checkOutput("b2b second cycle", 32'(rsp_cyc[1]), 32'd7);
        checkOutput("b2b second data", rsp_dat[1], 32'h0000_0089);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
